// File: rtl/fp_add_pkg.sv
// Shared constants and state encoding for the sequential single-precision adder.
package fp_add_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam int FP_BIAS   = 127;

    // Working significand: hidden, fraction, guard, round, sticky
    localparam int SIG_W = FP_FRAC_W + 4;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef enum logic [2:0] {
        IDLE,
        CMP,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } state_t;

endpackage

// File: rtl/fp_exp_compare.sv
// Exponent comparator: picks the larger exponent, its distance to the smaller,
// and whether operand B must become the primary (larger) operand.
module fp_exp_compare
    import fp_add_pkg::*;
(
    input  logic [FP_EXP_W-1:0] exp_a,
    input  logic [FP_EXP_W-1:0] exp_b,
    output logic [FP_EXP_W-1:0] exp_max,
    output logic [FP_EXP_W-1:0] diff,
    output logic                swap
);

    logic [FP_EXP_W:0] sub;

    // Single subtract; the borrow says B is larger and the difference is negated
    always_comb begin
        sub     = {1'b0, exp_a} - {1'b0, exp_b};
        swap    = sub[FP_EXP_W];
        exp_max = swap ? exp_b : exp_a;
        diff    = swap ? (exp_b - exp_a) : sub[FP_EXP_W-1:0];
    end

endmodule

// File: rtl/fp_add_seq_ctrl.sv
// Multi-cycle IEEE754 single-precision add/subtract sequencer with
// valid/ready handshakes on both sides.
module fp_add_seq_ctrl
    import fp_add_pkg::*;
#(
    parameter int unsigned MAX_ALIGN = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam int unsigned CNT_W = $clog2(MAX_ALIGN + 1);
    localparam int          SGN   = FP_EXP_W + FP_FRAC_W;

    state_t state, state_nxt;

    logic [31:0]         a_r, b_r, result_r;
    logic                sign_big, sign_small, special_r;
    logic [FP_EXP_W+1:0] exp_r;
    logic [SIG_W-1:0]    sig_big, sig_small;
    logic [CNT_W-1:0]    cnt;

    // CMP-stage decode
    logic [FP_EXP_W-1:0]  exp_a, exp_b, exp_max, diff;
    logic                 swap;
    logic                 a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
    logic [SIG_W-1:0]     sig_a, sig_b;
    logic                 is_special;
    logic [31:0]          special_val;
    logic [CNT_W-1:0]     align_d;

    // ADD / ROUND stage
    logic                 eff_sub, big_ge, add_zero, add_norm;
    logic [SIG_W:0]       sum;
    logic [SIG_W-1:0]     mag;
    logic                 rnd_inc;
    logic [FP_FRAC_W+1:0] rnd;
    logic [FP_EXP_W+1:0]  exp_fin;
    logic [FP_FRAC_W-1:0] frac_fin;
    logic [31:0]          round_val;

    fp_exp_compare u_exp_compare (
        .exp_a   (exp_a),
        .exp_b   (exp_b),
        .exp_max (exp_max),
        .diff    (diff),
        .swap    (swap)
    );

    // Operand classification, special-case results and alignment distance
    always_comb begin
        exp_a  = a_r[SGN-1:FP_FRAC_W];
        exp_b  = b_r[SGN-1:FP_FRAC_W];
        a_zero = (exp_a == '0);
        b_zero = (exp_b == '0);
        a_nan  = (exp_a == '1) && (a_r[FP_FRAC_W-1:0] != '0);
        b_nan  = (exp_b == '1) && (b_r[FP_FRAC_W-1:0] != '0);
        a_inf  = (exp_a == '1) && (a_r[FP_FRAC_W-1:0] == '0);
        b_inf  = (exp_b == '1) && (b_r[FP_FRAC_W-1:0] == '0);
        sig_a  = a_zero ? '0 : {1'b1, a_r[FP_FRAC_W-1:0], 3'b000};
        sig_b  = b_zero ? '0 : {1'b1, b_r[FP_FRAC_W-1:0], 3'b000};

        is_special  = 1'b1;
        special_val = '0;
        if (a_nan || b_nan)
            special_val = QNAN;
        else if (a_inf && b_inf)
            special_val = (a_r[SGN] == b_r[SGN]) ? a_r : QNAN;
        else if (a_inf)
            special_val = a_r;
        else if (b_inf)
            special_val = b_r;
        else if (a_zero && b_zero)
            special_val = {a_r[SGN] & b_r[SGN], 31'b0};
        else
            is_special = 1'b0;

        // Shifting MAX_ALIGN places already folds the whole smaller significand into sticky
        align_d = (diff > FP_EXP_W'(MAX_ALIGN)) ? CNT_W'(MAX_ALIGN) : diff[CNT_W-1:0];
    end

    // Significand add/subtract and round-to-nearest-even
    always_comb begin
        eff_sub  = sign_big ^ sign_small;
        sum      = {1'b0, sig_big} + {1'b0, sig_small};
        big_ge   = (sig_big >= sig_small);
        mag      = big_ge ? (sig_big - sig_small) : (sig_small - sig_big);
        add_zero = eff_sub && (mag == '0);
        add_norm = eff_sub ? mag[SIG_W-1] : (sum[SIG_W] | sum[SIG_W-1]);

        rnd_inc  = sig_big[2] & (sig_big[1] | sig_big[0] | sig_big[3]);
        rnd      = {1'b0, sig_big[SIG_W-1:3]} + (FP_FRAC_W+2)'(rnd_inc);
        exp_fin  = exp_r + (FP_EXP_W+2)'(rnd[FP_FRAC_W+1]);
        frac_fin = rnd[FP_FRAC_W+1] ? rnd[FP_FRAC_W:1] : rnd[FP_FRAC_W-1:0];
        if (exp_fin >= (FP_EXP_W+2)'(255))
            round_val = {sign_big, POS_INF[30:0]};
        else
            round_val = {sign_big, exp_fin[FP_EXP_W-1:0], frac_fin};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CMP;
            end
            // Special results pass through ROUND untouched to give a two-edge latency
            CMP: begin
                if (is_special)        state_nxt = ROUND;
                else if (align_d != '0) state_nxt = ALIGN;
                else                   state_nxt = ADD;
            end
            ALIGN: if (cnt == CNT_W'(1)) state_nxt = ADD;
            ADD: begin
                if (add_zero)      state_nxt = DONE;
                else if (add_norm) state_nxt = ROUND;
                else               state_nxt = NORM;
            end
            NORM: begin
                if (exp_r <= (FP_EXP_W+2)'(1)) state_nxt = DONE;
                else if (sig_big[SIG_W-2])     state_nxt = ROUND;
            end
            ROUND: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers stepped by the current state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r        <= '0;
            b_r        <= '0;
            result_r   <= '0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            special_r  <= 1'b0;
            exp_r      <= '0;
            sig_big    <= '0;
            sig_small  <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r <= in_a;
                    b_r <= {in_b[SGN] ^ in_sub, in_b[SGN-1:0]};
                end
                CMP: begin
                    special_r  <= is_special;
                    if (is_special) result_r <= special_val;
                    sign_big   <= swap ? b_r[SGN] : a_r[SGN];
                    sign_small <= swap ? a_r[SGN] : b_r[SGN];
                    sig_big    <= swap ? sig_b : sig_a;
                    sig_small  <= swap ? sig_a : sig_b;
                    exp_r      <= {2'b00, exp_max};
                    cnt        <= align_d;
                end
                ALIGN: begin
                    sig_small <= {1'b0, sig_small[SIG_W-1:2], sig_small[1] | sig_small[0]};
                    cnt       <= cnt - CNT_W'(1);
                end
                ADD: begin
                    if (eff_sub) begin
                        if (add_zero) result_r <= '0;
                        sig_big  <= mag;
                        sign_big <= big_ge ? sign_big : sign_small;
                    end else if (sum[SIG_W]) begin
                        sig_big <= {sum[SIG_W:2], sum[1] | sum[0]};
                        exp_r   <= exp_r + (FP_EXP_W+2)'(1);
                    end else begin
                        sig_big <= sum[SIG_W-1:0];
                    end
                end
                NORM: begin
                    if (exp_r <= (FP_EXP_W+2)'(1)) begin
                        result_r <= {sign_big, 31'b0};
                    end else begin
                        sig_big <= {sig_big[SIG_W-2:0], 1'b0};
                        exp_r   <= exp_r - (FP_EXP_W+2)'(1);
                    end
                end
                ROUND: if (!special_r) result_r <= round_val;
                default: ;
            endcase
        end
    end

    assign out_data = result_r;

endmodule
